// File: rtl/hdc_pkg.sv
// Shared constants and FSM state type for the hyperdimensional classifier search path.
package hdc_pkg;

    localparam int HV_DIM          = 4096;
    localparam int SEQ_CYCLE_COUNT = 4;
    localparam int DIMS_PER_CC     = HV_DIM / SEQ_CYCLE_COUNT;
    localparam int NUM_CLASSES     = 26;
    localparam int DIST_W          = 13;
    localparam int CLASS_IDX_W     = 5;
    localparam int CHUNK_IDX_W     = 2;
    localparam int PC_W            = 11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_FINISH
    } search_state_e;

endpackage

// File: rtl/popcount_chunk.sv
// Combinational popcount of one DIMS_PER_CC-bit chunk: 32-bit group counts, then a sum of groups.
module popcount_chunk
    import hdc_pkg::*;
(
    input  logic [DIMS_PER_CC-1:0] bits,
    output logic [PC_W-1:0]        count
);

    localparam int GRP  = 32;
    localparam int NGRP = DIMS_PER_CC / GRP;

    logic [5:0] grp_cnt [NGRP];

    always_comb begin
        count = '0;
        for (int g = 0; g < NGRP; g++) begin
            grp_cnt[g] = '0;
            for (int b = 0; b < GRP; b++) begin
                grp_cnt[g] = grp_cnt[g] + 6'(bits[g*GRP + b]);
            end
        end
        for (int g = 0; g < NGRP; g++) begin
            count = count + PC_W'(grp_cnt[g]);
        end
    end

endmodule

// File: rtl/class_similarity_search.sv
// Scans every stored class HV chunk by chunk against a latched query and reports the
// class with minimum Hamming distance (ties resolve to the lower class index).
module class_similarity_search
    import hdc_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [HV_DIM-1:0]      query_hv,
    output logic [CLASS_IDX_W-1:0] class_sel,
    output logic [CHUNK_IDX_W-1:0] chunk_sel,
    input  logic [DIMS_PER_CC-1:0] class_chunk,
    output logic                   busy,
    output logic                   done,
    output logic [CLASS_IDX_W-1:0] predicted_class,
    output logic [DIST_W-1:0]      min_distance,
    output search_state_e          dbg_state
);

    // Handshake: start is accepted only while idle (busy=0, not in the done cycle);
    // done pulses exactly once per accepted, non-aborted search, with results valid then.
    search_state_e state, state_nxt;

    logic [HV_DIM-1:0]      query_q;
    logic [DIMS_PER_CC-1:0] query_chunk;
    logic [PC_W-1:0]        pc_count;
    logic                   last_issue;

    logic                   pc_vld;
    logic [PC_W-1:0]        pc_q;
    logic [CLASS_IDX_W-1:0] pc_class;
    logic                   pc_last;

    logic [DIST_W-1:0]      acc;
    logic [DIST_W-1:0]      acc_next;
    logic [DIST_W-1:0]      best_dist;
    logic [CLASS_IDX_W-1:0] best_class;
    logic                   take_best;

    assign dbg_state   = state;
    assign query_chunk = query_q[int'(chunk_sel)*DIMS_PER_CC +: DIMS_PER_CC];
    assign last_issue  = (class_sel == CLASS_IDX_W'(NUM_CLASSES-1)) &&
                         (chunk_sel == CHUNK_IDX_W'(SEQ_CYCLE_COUNT-1));

    popcount_chunk u_popcount (
        .bits  (query_chunk ^ class_chunk),
        .count (pc_count)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE:   if (start) state_nxt = S_SCAN;
            S_SCAN: begin
                busy = 1'b1;
                if (last_issue) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy      = 1'b1;
                state_nxt = S_FINISH;
            end
            S_FINISH: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Chunk index runs fastest; class index advances on each chunk wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            query_q   <= '0;
            class_sel <= '0;
            chunk_sel <= '0;
        end else if (state == S_IDLE && start) begin
            query_q   <= query_hv;
            class_sel <= '0;
            chunk_sel <= '0;
        end else if (state == S_SCAN) begin
            if (last_issue) begin
                class_sel <= '0;
                chunk_sel <= '0;
            end else begin
                chunk_sel <= chunk_sel + 2'd1;
                if (chunk_sel == CHUNK_IDX_W'(SEQ_CYCLE_COUNT-1))
                    class_sel <= class_sel + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_vld   <= 1'b0;
            pc_q     <= '0;
            pc_class <= '0;
            pc_last  <= 1'b0;
        end else begin
            pc_vld   <= (state == S_SCAN);
            pc_q     <= pc_count;
            pc_class <= class_sel;
            pc_last  <= (chunk_sel == CHUNK_IDX_W'(SEQ_CYCLE_COUNT-1));
        end
    end

    assign acc_next  = acc + DIST_W'(pc_q);
    assign take_best = pc_vld && pc_last && ((pc_class == '0) || (acc_next < best_dist));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            best_dist  <= '0;
            best_class <= '0;
        end else begin
            if (pc_vld) acc <= pc_last ? '0 : acc_next;
            if (take_best) begin
                best_dist  <= acc_next;
                best_class <= pc_class;
            end
        end
    end

    // Class 25 is compared during DRAIN, so results take the live compare outcome.
    always_ff @(posedge clk) begin
        if (rst) begin
            predicted_class <= '0;
            min_distance    <= '0;
        end else if (state == S_DRAIN) begin
            predicted_class <= take_best ? pc_class : best_class;
            min_distance    <= take_best ? acc_next : best_dist;
        end
    end

endmodule

// File: tb/tb_class_similarity_search.sv
// Randomized bench for class_similarity_search against a whole-HV argmin reference model.
module tb_class_similarity_search;
    import hdc_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [HV_DIM-1:0]      query_hv;
    logic [CLASS_IDX_W-1:0] class_sel;
    logic [CHUNK_IDX_W-1:0] chunk_sel;
    logic [DIMS_PER_CC-1:0] class_chunk;
    logic                   busy;
    logic                   done;
    logic [CLASS_IDX_W-1:0] predicted_class;
    logic [DIST_W-1:0]      min_distance;
    search_state_e          dbg_state;

    logic [HV_DIM-1:0] class_mem [NUM_CLASSES];
    logic [HV_DIM-1:0] cls_word;
    logic [17:0]       exp_q [$];
    logic [17:0]       mon_exp;
    int                checks    = 0;
    int                errors    = 0;
    int                done_seen = 0;

    class_similarity_search dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .query_hv        (query_hv),
        .class_sel       (class_sel),
        .chunk_sel       (chunk_sel),
        .class_chunk     (class_chunk),
        .busy            (busy),
        .done            (done),
        .predicted_class (predicted_class),
        .min_distance    (min_distance),
        .dbg_state       (dbg_state)
    );

    always #5 clk = ~clk;

    // Class register file model: combinational readback of the selected chunk.
    always_comb begin
        cls_word    = (int'(class_sel) < NUM_CLASSES) ? class_mem[class_sel] : '0;
        class_chunk = cls_word[int'(chunk_sel)*DIMS_PER_CC +: DIMS_PER_CC];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [HV_DIM-1:0] rand_hv();
        logic [HV_DIM-1:0] v;
        for (int i = 0; i < HV_DIM/32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [HV_DIM-1:0] flip_bits(input logic [HV_DIM-1:0] v, input int n);
        logic [HV_DIM-1:0] m = '0;
        while ($countones(m) < n) m[$urandom_range(HV_DIM-1, 0)] = 1'b1;
        return v ^ m;
    endfunction

    // Reference: full-width Hamming distance per class, first strict minimum wins.
    function automatic logic [17:0] model(input logic [HV_DIM-1:0] q);
        int best_c = 0;
        int best_d = 0;
        int d;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            d = $countones(q ^ class_mem[c]);
            if (c == 0 || d < best_d) begin
                best_d = d;
                best_c = c;
            end
        end
        return {5'(best_c), 13'(best_d)};
    endfunction

    // Scoreboard: each done pulse consumes one expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_seen++;
            if (exp_q.size() == 0) check("unexpected_done", 1, 0);
            else begin
                mon_exp = exp_q.pop_front();
                check("predicted_class", 32'(predicted_class), 32'(mon_exp[17:13]));
                check("min_distance", 32'(min_distance), 32'(mon_exp[12:0]));
            end
        end
    end

    // Drives one search; intr_at injects a stray start, rst_at aborts with reset (0 = off).
    task automatic run_search(input logic [HV_DIM-1:0] q, input int intr_at, input int rst_at);
        int          k  = 0;
        int          got = 0;
        int          d0 = done_seen;
        logic [17:0] e  = model(q);
        @(negedge clk);
        query_hv = q;
        start    = 1'b1;
        exp_q.push_back(e);
        while (k < 200 && got == 0) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            rst   = 1'b0;
            if (done === 1'b1) got = k;
            if (k <= 104 && (rst_at == 0 || k <= rst_at)) begin
                check("scan_class_sel", 32'(class_sel), 32'((k-1)/4));
                check("scan_chunk_sel", 32'(chunk_sel), 32'((k-1)%4));
                check("scan_busy", 32'(busy), 1);
            end
            if (rst_at > 0 && k == rst_at + 1) begin
                check("abort_busy", 32'(busy), 0);
                check("abort_class", 32'(predicted_class), 0);
                check("abort_dist", 32'(min_distance), 0);
                exp_q.delete();
            end
            if (k == intr_at) begin
                start    = 1'b1;
                query_hv = ~q;
            end
            if (k == rst_at) rst = 1'b1;
        end
        @(negedge clk);
        if (rst_at > 0) begin
            check("abort_no_done", 32'(got), 0);
            check("abort_done_count", 32'(done_seen - d0), 0);
        end else begin
            check("latency", 32'(got), 106);
            check("done_count", 32'(done_seen - d0), 1);
            check("hold_class", 32'(predicted_class), 32'(e[17:13]));
            check("hold_dist", 32'(min_distance), 32'(e[12:0]));
            check("idle_busy", 32'(busy), 0);
            check("idle_class_sel", 32'(class_sel), 0);
            check("idle_state", 32'(dbg_state), 32'(S_IDLE));
        end
    endtask

    logic [HV_DIM-1:0] q;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        query_hv = '0;
        for (int c = 0; c < NUM_CLASSES; c++) class_mem[c] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_class", 32'(predicted_class), 0);
        check("rst_dist", 32'(min_distance), 0);
        check("rst_class_sel", 32'(class_sel), 0);
        check("rst_chunk_sel", 32'(chunk_sel), 0);

        // Exact match on class 7.
        q = rand_hv();
        for (int c = 0; c < NUM_CLASSES; c++) class_mem[c] = rand_hv();
        class_mem[7] = q;
        run_search(q, 0, 0);

        // Maximum distance everywhere.
        for (int c = 0; c < NUM_CLASSES; c++) class_mem[c] = '0;
        run_search({HV_DIM{1'b1}}, 0, 0);

        // Tie between classes 3 and 12.
        q = rand_hv();
        for (int c = 0; c < NUM_CLASSES; c++) class_mem[c] = flip_bits(q, $urandom_range(200, 100));
        class_mem[3]  = flip_bits(q, 5);
        class_mem[12] = flip_bits(q, 5);
        run_search(q, 0, 0);

        // Last class wins with distance 1 in chunk 0, then 4 bits spread across chunks.
        q = rand_hv();
        for (int c = 0; c < NUM_CLASSES; c++) class_mem[c] = rand_hv();
        class_mem[25]    = q;
        class_mem[25][0] = ~q[0];
        run_search(q, 0, 0);
        class_mem[25] = q;
        class_mem[25][5]    = ~q[5];
        class_mem[25][1500] = ~q[1500];
        class_mem[25][2100] = ~q[2100];
        class_mem[25][4000] = ~q[4000];
        run_search(q, 0, 0);

        // Stray start mid-scan, then reset abort followed by a clean search.
        q = rand_hv();
        for (int c = 0; c < NUM_CLASSES; c++) class_mem[c] = flip_bits(q, $urandom_range(60, 0));
        run_search(q, 50, 0);
        run_search(q, 0, 60);
        run_search(q, 0, 0);

        // Random near-query classes; ties are likely and exercise the strict compare.
        for (int t = 0; t < 6; t++) begin
            q = rand_hv();
            for (int c = 0; c < NUM_CLASSES; c++) class_mem[c] = flip_bits(q, $urandom_range(40, 0));
            run_search(q, 0, 0);
        end

        check("exp_q_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/class_similarity_search.md
Name: class_similarity_search

Overview:
Inference-stage associative search placed directly downstream of the binary class hypervector registers. It takes a query encoded HV and scans all 26 binary class HVs in 1024-dim chunks, one chunk per cycle. For each class it accumulates the Hamming distance, then reports the class index with the minimum distance. Class chunks are read through a select/readback interface driven by this block.

Parameters:
HV_DIM, 4096, hypervector dimensionality
SEQ_CYCLE_COUNT, 4, chunks per HV
DIMS_PER_CC, 1024, dims per chunk (HV_DIM/SEQ_CYCLE_COUNT)
NUM_CLASSES, 26, number of stored classes
DIST_W, 13, distance width (clog2(HV_DIM)+1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin a search; sampled only in IDLE
query_hv  in  HV_DIM  encoded query HV; sampled with start
class_sel  out  5  class index being read
chunk_sel  out  2  chunk index being read
class_chunk  in  DIMS_PER_CC  binary class chunk for class_sel/chunk_sel; combinational, valid in the same cycle
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse; results valid
predicted_class  out  5  argmin class index
min_distance  out  DIST_W  Hamming distance of predicted_class

Behaviour:
- Reset: one clock and one reset; reset is synchronous and active-high. rst forces state IDLE. busy=0, done=0, predicted_class=0, min_distance=0, class_sel=0, chunk_sel=0. All accumulators and pipeline valids are cleared. rst has priority over every other input, including in the middle of a scan; no done is issued for an aborted search.
- FSM states: IDLE, SCAN, DRAIN, FINISH.
- IDLE:
  - When start=1, latch query_hv into query_q and set class_sel=0, chunk_sel=0.
  - Go to SCAN. busy rises in the next cycle.
- SCAN:
  - Each cycle, compute xor of query_q chunk[chunk_sel] with class_chunk.
  - Register its popcount into pc_q, with tags pc_class=class_sel, pc_last=(chunk_sel==3), and set pc_vld=1.
  - Counter: chunk_sel increments and wraps 3->0. On that wrap, class_sel increments.
  - After issuing class 25 chunk 3, go to DRAIN. Exactly NUM_CLASSES*SEQ_CYCLE_COUNT = 104 SCAN cycles.
- Accumulate stage (runs whenever pc_vld=1):
  - acc_next = acc + pc_q.
  - If pc_last=0: acc <= acc_next.
  - If pc_last=1: compare acc_next with best_dist, then set acc <= 0.
- Compare rule:
  - pc_class==0 loads best unconditionally.
  - Otherwise update only if acc_next < best_dist (strict). Ties therefore keep the lower class index.
- DRAIN: one cycle; the final compare for class 25 completes. Go to FINISH.
- FINISH:
  - done=1 for this single cycle; predicted_class and min_distance are updated from best.
  - busy=0, return to IDLE.
- Latency: start sampled in cycle N gives done in cycle N+106.
- Results hold until the next FINISH or reset.
- start while busy is ignored, and query_q is not overwritten.
- start in the FINISH cycle is ignored. A new start is accepted in IDLE from cycle N+107.
- Width rules:
  - popcount is 11 bits (max 1024).
  - Accumulator and distance are DIST_W bits; maximum 4096 is representable, no saturation needed.
- class_sel/chunk_sel hold 0 in IDLE and FINISH. Upstream needs no enable; reads have no side effects.

Decomposition:
- Shared package hdc_pkg holds HV_DIM, SEQ_CYCLE_COUNT, DIMS_PER_CC, NUM_CLASSES, DIST_W, CLASS_IDX_W=5, CHUNK_IDX_W=2, and an enum for the search FSM states.
- One sub-module: popcount_chunk, a purely combinational adder tree over DIMS_PER_CC bits producing an 11-bit count.
- FSM, counters, accumulator and comparator stay in class_similarity_search.

Test Plan:
- Class HVs random except class 7 == query; start -> done at N+106, predicted_class=7, min_distance=0.
- Query all ones, all classes all zeros -> predicted_class=0, min_distance=4096 (no overflow).
- Classes 3 and 12 both at distance 5, others larger -> predicted_class=3, min_distance=5 (tie keeps lower index).
- Class 25 at distance 1, others ≥100 -> predicted_class=25, min_distance=1 (last class compared via DRAIN). Distances split across chunks, e.g. 1,0,0,0 per chunk -> sum correct.
- Second start pulsed at N+50 with a different query_hv -> ignored; result matches the first query; exactly one done pulse.
- rst asserted at N+60 -> next cycle busy=0, predicted_class=0, min_distance=0, no done. A new start then completes normally at +106.
